// File: rtl/niosii_ram_pkt_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : niosii_ram_pkt_writer_pkg
//  Description : Shared constants and FSM state type for the packet writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package niosii_ram_pkt_writer_pkg;

    localparam int c_LANES  = 4;
    localparam int c_BYTE_W = 8;
    localparam int c_WORD_W = c_LANES * c_BYTE_W;
    localparam int c_LANE_W = $clog2(c_LANES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOP = 3'd1,
        ST_PACK     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage : niosii_ram_pkt_writer_pkg
`default_nettype wire

// File: rtl/niosii_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : niosii_byte_packer
//  Description : Little-endian byte-to-word accumulator with lane enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module niosii_byte_packer
    import niosii_ram_pkt_writer_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                push,
    input  logic [c_BYTE_W-1:0] byte_in,
    output logic [c_WORD_W-1:0] word,
    output logic [c_LANES-1:0]  byteenable,
    output logic                word_full
);

    logic [c_WORD_W-1:0] r_word;
    logic [c_LANES-1:0]  r_be;
    logic [c_LANE_W-1:0] r_lane;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word <= '0;
            r_be   <= '0;
            r_lane <= '0;
        end else if (clear) begin
            r_word <= '0;
            r_be   <= '0;
            r_lane <= '0;
        end else if (push) begin
            r_word[{r_lane, 3'b000} +: c_BYTE_W] <= byte_in;
            r_be[r_lane]                         <= 1'b1;
            r_lane                               <= r_lane + 1'b1;
        end
    end

    // Asserted on the push that fills the last lane.
    assign word_full  = push && (r_lane == c_LANE_W'(c_LANES - 1));
    assign word       = r_word;
    assign byteenable = r_be;

endmodule : niosii_byte_packer
`default_nettype wire

// File: rtl/niosii_ram_pkt_writer.sv
`default_nettype none
// ============================================================================
//  Module      : niosii_ram_pkt_writer
//  Description : Captures one Avalon-ST byte packet into on-chip RAM as words.
//  Revision    : 1.0 - initial release
// ============================================================================
module niosii_ram_pkt_writer
    import niosii_ram_pkt_writer_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024,
    parameter int LEN_W     = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                arm,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [c_BYTE_W-1:0] st_data,
    input  logic                st_valid,
    input  logic                st_sop,
    input  logic                st_eop,
    output logic                st_ready,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [c_LANES-1:0]  m_byteenable,
    output logic [c_WORD_W-1:0] m_writedata,
    input  logic                m_waitrequest,
    output logic                done,
    output logic [LEN_W-1:0]    pkt_len,
    output logic                overflow,
    output logic                busy
);

    localparam int c_WCNT_W = $clog2(MAX_WORDS + 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_WCNT_W-1:0] r_word_cnt;
    logic                r_full;
    logic                r_eop_word;
    logic [LEN_W-1:0]    r_byte_cnt;
    logic                r_ovf_seen;

    logic w_push;
    logic w_clear;
    logic w_discard;
    logic w_write_done;
    logic w_word_full;

    assign st_ready     = (r_state == ST_WAIT_SOP) || (r_state == ST_PACK);
    assign w_write_done = (r_state == ST_WRITE) && !m_waitrequest;
    assign w_clear      = w_write_done || ((r_state == ST_IDLE) && arm);
    assign w_discard    = (r_state == ST_PACK) && st_valid && r_full;
    assign w_push       = ((r_state == ST_WAIT_SOP) && st_valid && st_sop)
                        || ((r_state == ST_PACK) && st_valid && !r_full);

    niosii_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (w_clear),
        .push       (w_push),
        .byte_in    (st_data),
        .word       (m_writedata),
        .byteenable (m_byteenable),
        .word_full  (w_word_full)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (arm) w_next = ST_WAIT_SOP;
            ST_WAIT_SOP: if (w_push) w_next = st_eop ? ST_WRITE : ST_PACK;
            ST_PACK: begin
                // Once the window is full, bytes are drained until end of packet.
                if (w_discard && st_eop)
                    w_next = ST_DONE;
                else if (w_push && (w_word_full || st_eop))
                    w_next = ST_WRITE;
            end
            ST_WRITE:    if (w_write_done) w_next = r_eop_word ? ST_DONE : ST_PACK;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_full     <= 1'b0;
            r_eop_word <= 1'b0;
            r_byte_cnt <= '0;
            r_ovf_seen <= 1'b0;
            pkt_len    <= '0;
            overflow   <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && arm) begin
                r_addr     <= base_addr;
                r_word_cnt <= '0;
                r_full     <= 1'b0;
                r_eop_word <= 1'b0;
                r_byte_cnt <= '0;
                r_ovf_seen <= 1'b0;
                pkt_len    <= '0;
                overflow   <= 1'b0;
            end
            if (w_push) begin
                r_eop_word <= st_eop;
                if (r_byte_cnt != '1)
                    r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            if (w_discard)
                r_ovf_seen <= 1'b1;
            if (w_write_done) begin
                r_addr     <= r_addr + 1'b1;
                r_word_cnt <= r_word_cnt + 1'b1;
                if (r_word_cnt == c_WCNT_W'(MAX_WORDS - 1))
                    r_full <= 1'b1;
            end
            if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
                pkt_len  <= r_byte_cnt;
                overflow <= r_ovf_seen || w_discard;
            end
        end
    end

    assign m_address    = r_addr;
    assign m_chipselect = (r_state == ST_WRITE);
    assign m_write      = (r_state == ST_WRITE);
    assign done         = (r_state == ST_DONE);
    assign busy         = (r_state != ST_IDLE);

endmodule : niosii_ram_pkt_writer
`default_nettype wire

// File: doc/niosii_ram_pkt_writer.md
NIOSII_RAM_PKT_WRITER -- requirements
Module: niosii_ram_pkt_writer

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the target on-chip RAM.
REQ-002 Parameter MAX_WORDS, default 1024, capture window size in 32-bit words.
REQ-003 Parameter LEN_W, default 12, width of the byte-length counter.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 arm  input  1  one-cycle pulse; starts a capture (honoured in IDLE only).
REQ-007 base_addr  input  ADDR_W  first word address of the capture; sampled on arm.
REQ-008 st_data  input  8  Avalon-ST byte from the Ethernet receive path.
REQ-009 st_valid, st_sop, st_eop  input  1 each  stream valid, start-of-packet, end-of-packet.
REQ-010 st_ready  output  1  stream backpressure.
REQ-011 m_address  output  ADDR_W  Avalon-MM word address to the RAM slave.
REQ-012 m_chipselect, m_write  output  1 each  write-request qualifiers.
REQ-013 m_byteenable  output  4  lane enables; bit n covers writedata[8n+7:8n].
REQ-014 m_writedata  output  32  packed word.
REQ-015 m_waitrequest  input  1  slave stall; tie 0 for the on-chip RAM.
REQ-016 done  output  1  one-cycle pulse when a capture finishes.
REQ-017 pkt_len  output  LEN_W  bytes stored by the last capture; valid from done.
REQ-018 overflow  output  1  last capture exceeded MAX_WORDS; valid from done.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states IDLE, WAIT_SOP, PACK, WRITE, DONE.
REQ-021 IDLE: st_ready=0; arm -> latch base_addr, clear byte count and overflow, go WAIT_SOP.
REQ-022 WAIT_SOP: st_ready=1; accepted bytes without st_sop are discarded; an accepted st_sop byte is packed as lane 0, state PACK.
REQ-023 Packing is little-endian: k-th byte of a word (k=0..3) goes to bits 8k+7:8k with byteenable bit k set.
REQ-024 PACK: st_ready=1; on the 4th byte of a word or on an st_eop byte, go WRITE next cycle.
REQ-025 WRITE: st_ready=0, m_chipselect=m_write=1, address/data/byteenable held stable while m_waitrequest=1.
REQ-026 WRITE completes on the cycle m_waitrequest=0; next state PACK, or DONE if the word held st_eop; word address increments by 1 modulo 2^ADDR_W.
REQ-027 Final partial word carries only the lanes filled (e.g. 2 bytes -> 4'b0011); unused data lanes are 0.
REQ-028 st_sop on a byte accepted in PACK is treated as ordinary data.
REQ-029 st_sop and st_eop on the same byte form a 1-byte packet: one write, byteenable 4'b0001, pkt_len 1.
REQ-030 Once MAX_WORDS words have been written, further bytes are accepted and discarded until st_eop; overflow set; pkt_len = 4*MAX_WORDS.
REQ-031 pkt_len counts stored bytes only and saturates at 2^LEN_W-1.
REQ-032 DONE: done=1 for exactly one cycle, pkt_len/overflow updated, next state IDLE; they hold until the next arm.
REQ-033 arm outside IDLE is ignored.
REQ-034 Throughput: 4 bytes accepted per 5 cycles with m_waitrequest=0.

Reset
REQ-035 reset_n low asynchronously forces IDLE; st_ready, m_chipselect, m_write, done, busy, overflow = 0; m_address, m_byteenable, m_writedata, pkt_len = 0.
REQ-036 Reset mid-WRITE drops the request immediately; no partial capture state survives.

Structure
REQ-037 Shared package holds the FSM state enum, lane count (4), and byte/word width constants.
REQ-038 One sub-module, niosii_byte_packer: accumulates bytes into word/byteenable, signals word_full.

Verification
REQ-039 base_addr=0x010, 8-byte packet 01..08 -> writes 0x04030201 @0x010 and 0x08070605 @0x011, BE 4'hF both, pkt_len=8, overflow=0.
REQ-040 6-byte packet AA..FF at base 0x3FF -> 0xDDCCBBAA @0x3FF, 0x0000FFEE @0x000 BE 4'b0011, pkt_len=6.
REQ-041 single byte 0x5A with sop+eop -> one write 0x0000005A BE 4'b0001, pkt_len=1, done one cycle.
REQ-042 m_waitrequest held high 3 cycles during first write -> outputs stable, st_ready=0 throughout, data identical to REQ-039.
REQ-043 MAX_WORDS=2, 12-byte packet -> exactly 2 writes, bytes 9..12 consumed, overflow=1, pkt_len=8.
REQ-044 reset_n asserted during WRITE -> m_write=0 same cycle, busy=0; next arm and 4-byte packet captures correctly.
